// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters: round-robin grants,
// locked multi-transfer sequences, done routing and a stall watchdog.
module spi_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 13,
    parameter logic [2:0]  SS_NONE     = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_wrt,
    input  logic [2:0]  req0_ss,
    input  logic [15:0] req0_data,
    input  logic        req0_lock,
    output logic        req0_done,
    input  logic        req1_wrt,
    input  logic [2:0]  req1_ss,
    input  logic [15:0] req1_data,
    input  logic        req1_lock,
    output logic        req1_done,
    output logic        spi_wrt,
    output logic [2:0]  spi_ss,
    output logic [15:0] spi_data,
    input  logic        spi_done,
    output logic        busy,
    output logic        owner,
    output logic        err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_HOLD} state_t;

    state_t state_q, state_d;
    logic owner_q, owner_d, rr_q, rr_d, lock_q, lock_d;
    logic pend0_q, pend0_d, pend1_q, pend1_d;
    logic [2:0] ss0_q, ss0_d, ss1_q, ss1_d;
    logic [15:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic lk0_q, lk0_d, lk1_q, lk1_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic wrt_q, wrt_d, done0_q, done0_d, done1_q, done1_d;
    logic err_q, err_d, busy_q, busy_d;
    logic [2:0] sso_q, sso_d;
    logic [15:0] dato_q, dato_d;

    // A request counts in the cycle its pulse arrives, giving 1-cycle grant latency
    logic e0, e1, el0, el1;
    logic [2:0] ess0, ess1;
    logic [15:0] ed0, ed1;
    logic wd_hit, launch, lsel;

    assign e0   = pend0_q | req0_wrt;
    assign e1   = pend1_q | req1_wrt;
    assign ess0 = pend0_q ? ss0_q : req0_ss;
    assign ess1 = pend1_q ? ss1_q : req1_ss;
    assign ed0  = pend0_q ? dat0_q : req0_data;
    assign ed1  = pend1_q ? dat1_q : req1_data;
    assign el0  = pend0_q ? lk0_q : req0_lock;
    assign el1  = pend1_q ? lk1_q : req1_lock;
    assign wd_hit = (wd_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        pend0_d = pend0_q | req0_wrt;
        pend1_d = pend1_q | req1_wrt;
        ss0_d   = ss0_q;
        dat0_d  = dat0_q;
        lk0_d   = lk0_q;
        ss1_d   = ss1_q;
        dat1_d  = dat1_q;
        lk1_d   = lk1_q;
        wd_d    = (state_q == S_IDLE) ? '0 : wd_q + TO_W'(1);
        wrt_d   = 1'b0;
        sso_d   = sso_q;
        dato_d  = dato_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
        launch  = 1'b0;
        lsel    = owner_q;

        if (req0_wrt && !pend0_q) begin
            ss0_d  = req0_ss;
            dat0_d = req0_data;
            lk0_d  = req0_lock;
        end
        if (req1_wrt && !pend1_q) begin
            ss1_d  = req1_ss;
            dat1_d = req1_data;
            lk1_d  = req1_lock;
        end

        unique case (state_q)
            S_IDLE: begin
                if (e0 && e1) begin
                    launch = 1'b1;
                    lsel   = rr_q;
                    rr_d   = ~rr_q;
                end else if (e0 || e1) begin
                    launch = 1'b1;
                    lsel   = e1;
                end
            end
            S_XFER: begin
                if (spi_done || wd_hit) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    sso_d   = SS_NONE;
                    err_d   = ~spi_done;
                    state_d = (spi_done && lock_q) ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (owner_q ? e1 : e0) begin
                    launch = 1'b1;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    sso_d   = SS_NONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d = S_XFER;
            owner_d = lsel;
            wrt_d   = 1'b1;
            sso_d   = lsel ? ess1 : ess0;
            dato_d  = lsel ? ed1 : ed0;
            lock_d  = lsel ? el1 : el0;
            if (lsel) pend1_d = 1'b0;
            else      pend0_d = 1'b0;
        end

        if (state_d != state_q) wd_d = '0;
        busy_d = (state_d != S_IDLE) || pend0_d || pend1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            lock_q  <= 1'b0;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            ss0_q   <= '0;
            dat0_q  <= '0;
            lk0_q   <= 1'b0;
            ss1_q   <= '0;
            dat1_q  <= '0;
            lk1_q   <= 1'b0;
            wd_q    <= '0;
            wrt_q   <= 1'b0;
            sso_q   <= SS_NONE;
            dato_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            ss0_q   <= ss0_d;
            dat0_q  <= dat0_d;
            lk0_q   <= lk0_d;
            ss1_q   <= ss1_d;
            dat1_q  <= dat1_d;
            lk1_q   <= lk1_d;
            wd_q    <= wd_d;
            wrt_q   <= wrt_d;
            sso_q   <= sso_d;
            dato_q  <= dato_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign spi_wrt     = wrt_q;
    assign spi_ss      = sso_q;
    assign spi_data    = dato_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed scenarios plus a randomized phase checked against a
// transaction-level model of the arbitration rules.
module tb_spi_arbiter;

    localparam int TO = 4096;
    localparam logic [2:0] SSN = 3'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_wrt = 0, req0_lock = 0, req1_wrt = 0, req1_lock = 0;
    logic [2:0] req0_ss = '0, req1_ss = '0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic spi_done = 0;
    logic req0_done, req1_done, spi_wrt, busy, owner, err_timeout;
    logic [2:0] spi_ss;
    logic [15:0] spi_data;

    int total = 0;
    int bad = 0;

    spi_arbiter #(.TIMEOUT_CYC(TO), .TO_W(13), .SS_NONE(SSN)) dut (
        .clk(clk), .rst(rst),
        .req0_wrt(req0_wrt), .req0_ss(req0_ss), .req0_data(req0_data),
        .req0_lock(req0_lock), .req0_done(req0_done),
        .req1_wrt(req1_wrt), .req1_ss(req1_ss), .req1_data(req1_data),
        .req1_lock(req1_lock), .req1_done(req1_done),
        .spi_wrt(spi_wrt), .spi_ss(spi_ss), .spi_data(spi_data),
        .spi_done(spi_done), .busy(busy), .owner(owner),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int r, input logic w, input logic [2:0] ss,
                       input logic [15:0] d, input logic lk);
        if (r == 0) begin
            req0_wrt = w; req0_ss = ss; req0_data = d; req0_lock = lk;
        end else begin
            req1_wrt = w; req1_ss = ss; req1_data = d; req1_lock = lk;
        end
    endtask

    task automatic fin_done();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
    endtask

    task automatic wait_err(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!err_timeout && n < TO + 500) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    // transaction-level model state for the random phase
    logic outs[2], awt[2], wlk[2];
    logic [2:0] wss[2];
    logic [15:0] wdat[2];
    int dly[2], seql[2];
    logic ptr, lk_act, lk_own, infl, dpend, cur_own;
    int cd, e, nx;

    initial begin
        repeat (3) tick();
        chk("rst_wrt", spi_wrt, 0);
        chk("rst_ss", spi_ss, SSN);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_done", {req0_done, req1_done, err_timeout}, 0);
        rst = 1'b0;
        tick();

        // single request, 1-cycle latency
        drv(0, 1, 3'd1, 16'h1302, 0);
        tick();
        drv(0, 0, 0, 0, 0);
        chk("t1_wrt", spi_wrt, 1);
        chk("t1_data", spi_data, 16'h1302);
        chk("t1_ss", spi_ss, 3'd1);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_wrt_pulse", spi_wrt, 0);
        chk("t1_ss_hold", spi_ss, 3'd1);
        tick();
        fin_done();
        chk("t1_done0", req0_done, 1);
        chk("t1_done1", req1_done, 0);
        chk("t1_busy_lo", busy, 0);
        chk("t1_ss_none", spi_ss, SSN);
        tick();
        chk("t1_done_pulse", req0_done, 0);

        // simultaneous requests, twice: round-robin alternates
        for (int rep = 0; rep < 2; rep++) begin
            drv(0, 1, 3'd2, 16'hA000 + 16'(rep), 0);
            drv(1, 1, 3'd3, 16'hB111 + 16'(rep), 0);
            tick();
            drv(0, 0, 0, 0, 0);
            drv(1, 0, 0, 0, 0);
            chk("t2_first_wrt", spi_wrt, 1);
            chk("t2_first_own", owner, rep);
            chk("t2_first_dat", spi_data,
                rep == 0 ? 16'hA000 : 16'hB112);
            tick();
            fin_done();
            chk("t2_first_done", {req1_done, req0_done},
                rep == 0 ? 2'b01 : 2'b10);
            chk("t2_gap", spi_wrt, 0);
            tick();
            chk("t2_second_wrt", spi_wrt, 1);
            chk("t2_second_own", owner, 1 - rep);
            chk("t2_second_dat", spi_data,
                rep == 0 ? 16'hB111 : 16'hA001);
            fin_done();
            chk("t2_second_done", {req1_done, req0_done},
                rep == 0 ? 2'b10 : 2'b01);
            tick();
        end

        // req1 locked 3-transfer read while req0 waits
        drv(1, 1, 3'd5, 16'h0300, 1);
        tick();
        drv(1, 0, 0, 0, 0);
        chk("t3_w1_own", owner, 1);
        drv(0, 1, 3'd4, 16'h4444, 0);
        tick();
        drv(0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            fin_done();
            chk("t3_done1", req1_done, 1);
            drv(1, 1, 3'd5, 16'h0301 + 16'(k), k == 0);
            tick();
            drv(1, 0, 0, 0, 0);
            chk("t3_hold_wrt", spi_wrt, 1);
            chk("t3_hold_own", owner, 1);
            chk("t3_hold_dat", spi_data, 16'h0301 + 16'(k));
        end
        fin_done();
        chk("t3_last_done", req1_done, 1);
        chk("t3_no_early", spi_wrt, 0);
        tick();
        chk("t3_r0_wrt", spi_wrt, 1);
        chk("t3_r0_own", owner, 0);
        chk("t3_r0_dat", spi_data, 16'h4444);
        fin_done();
        chk("t3_r0_done", req0_done, 1);
        tick();

        // stalled transfer
        drv(0, 1, 3'd6, 16'h5A5A, 0);
        tick();
        drv(0, 0, 0, 0, 0);
        chk("t4_wrt", spi_wrt, 1);
        wait_err("t4_latency", TO);
        chk("t4_err", err_timeout, 1);
        chk("t4_done0", req0_done, 1);
        chk("t4_ss", spi_ss, SSN);
        chk("t4_busy", busy, 0);
        tick();
        chk("t4_err_pulse", {err_timeout, req0_done}, 0);

        // abandoned lock with req0 waiting
        drv(1, 1, 3'd7, 16'h7777, 1);
        tick();
        drv(1, 0, 0, 0, 0);
        chk("t5_own", owner, 1);
        drv(0, 1, 3'd2, 16'h2222, 0);
        tick();
        drv(0, 0, 0, 0, 0);
        fin_done();
        chk("t5_done1", req1_done, 1);
        wait_err("t5_latency", TO);
        chk("t5_nodone", {req0_done, req1_done}, 0);
        chk("t5_ss", spi_ss, SSN);
        tick();
        chk("t5_r0_wrt", spi_wrt, 1);
        chk("t5_r0_own", owner, 0);
        chk("t5_r0_dat", spi_data, 16'h2222);
        fin_done();
        chk("t5_r0_done", req0_done, 1);
        tick();

        // reset mid-transfer with req1 pending
        drv(0, 1, 3'd1, 16'h1111, 0);
        tick();
        drv(0, 0, 0, 0, 0);
        drv(1, 1, 3'd3, 16'h3333, 0);
        tick();
        drv(1, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_out", {spi_wrt, busy, owner, req0_done,
            req1_done, err_timeout}, 0);
        chk("t6_rst_ss", spi_ss, SSN);
        chk("t6_rst_dat", spi_data, 0);
        fin_done();
        chk("t6_late_done", {req0_done, req1_done}, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_idle", {spi_wrt, busy}, 0);
        end

        // randomized phase against the transaction model
        for (int r = 0; r < 2; r++) begin
            outs[r] = 0; awt[r] = 0; dly[r] = 0; seql[r] = 0;
            wss[r] = '0; wdat[r] = '0; wlk[r] = 0;
        end
        ptr = 0; lk_act = 0; lk_own = 0; infl = 0;
        dpend = 0; cur_own = 0; cd = 0; nx = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            chk("r_err", err_timeout, 0);
            if (dpend) begin
                chk("r_done0", req0_done, cur_own == 0);
                chk("r_done1", req1_done, cur_own == 1);
                chk("r_ss_none", spi_ss, SSN);
                awt[cur_own] = 0;
                dly[cur_own] = $urandom_range(0, 3);
                dpend = 0;
            end else begin
                chk("r_nodone", {req0_done, req1_done}, 0);
            end
            if (spi_wrt) begin
                chk("r_overlap", infl, 0);
                if (lk_act) e = lk_own;
                else if (outs[0] && outs[1]) begin
                    e = ptr;
                    ptr = ~ptr;
                end else if (outs[0]) e = 0;
                else if (outs[1]) e = 1;
                else e = 2;
                chk("r_grant_owner", owner, e);
                if (e < 2) begin
                    chk("r_data", spi_data, wdat[e]);
                    chk("r_ss", spi_ss, wss[e]);
                    outs[e] = 0;
                    awt[e] = 1;
                    lk_act = wlk[e];
                    lk_own = e[0];
                    cur_own = e[0];
                end
                infl = 1;
                nx++;
                cd = $urandom_range(1, 5);
            end
            spi_done = 0;
            if (infl) begin
                if (cd == 0) begin
                    spi_done = 1;
                    dpend = 1;
                    infl = 0;
                end else cd--;
            end
            for (int r = 0; r < 2; r++) begin
                drv(r, 0, 0, 0, 0);
                if (!outs[r] && !awt[r]) begin
                    if (dly[r] > 0) dly[r]--;
                    else if (seql[r] > 0 || $urandom_range(0, 1) == 1) begin
                        if (seql[r] == 0) seql[r] = $urandom_range(1, 3);
                        wlk[r] = seql[r] > 1;
                        wss[r] = 3'($urandom_range(1, 7));
                        wdat[r] = 16'($urandom);
                        seql[r]--;
                        outs[r] = 1;
                        drv(r, 1, wss[r], wdat[r], wlk[r]);
                    end
                end
            end
        end
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        spi_done = 0;
        chk("r_activity", nx > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
